draw_board: RTL

Overlays per-cell game state (ship, hit, miss) and a blinking cursor onto a 12×12 playboard of 32-pixel cells in the VGA pixel chain. Sits directly upstream of the grid-line drawer, in the order background → draw_board → grid drawer, and uses the same X_POS/Y_POS board origin. It owns the 144-entry board-state memory, which game logic writes through a simple write port. All vga_if timing signals pass through with a fixed 2-cycle delay.

---
 rtl/game_pkg.sv | 49 ++++
 rtl/vga_if.sv | 14 +
 rtl/board_mem.sv | 26 ++
 rtl/draw_board.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared board-game definitions: cell states, board geometry, overlay colours
// and small helpers used by the board overlay and its memory.
package game_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SHIP  = 2'd1,
        HIT   = 2'd2,
        MISS  = 2'd3
    } cell_state_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    localparam int CELL_SIZE   = 32;
    localparam int BOARD_CELLS = 12;
    localparam int GRID_SIZE   = 384;
    localparam int BOARD_WORDS = BOARD_CELLS * BOARD_CELLS;

    localparam logic [11:0] SHIP_RGB   = 12'h888;
    localparam logic [11:0] HIT_RGB    = 12'hF00;
    localparam logic [11:0] MISS_RGB   = 12'h00F;
    localparam logic [11:0] CURSOR_RGB = 12'hFF0;

    // Row-major cell address: row*12 + col.
    function automatic logic [7:0] cell_addr(input logic [3:0] row, input logic [3:0] col);
        logic [7:0] row8;
        row8 = {4'd0, row};
        return row8 * 8'(BOARD_CELLS) + {4'd0, col};
    endfunction

    // Colour of a filled cell pixel; EMPTY lets the upstream colour through.
    function automatic logic [11:0] cell_rgb(input cell_state_t state, input logic [11:0] pass);
        case (state)
            SHIP:    return SHIP_RGB;
            HIT:     return HIT_RGB;
            MISS:    return MISS_RGB;
            default: return pass;
        endcase
    endfunction

    // Offsets forming the two-pixel cursor ring just inside the grid lines.
    function automatic logic ring_offset(input logic [4:0] ofs);
        return (ofs == 5'd2) || (ofs == 5'd3) || (ofs == 5'd30) || (ofs == 5'd31);
    endfunction

endpackage

// File: rtl/vga_if.sv
// VGA pixel-chain bundle: counters, syncs, blanking and colour of one pixel.
// The "in" modport is the receiving side, "out" the driving side.
interface vga_if;
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
    modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/board_mem.sv
// 144 x 2-bit board-state RAM: one write port, synchronous read-first read.
module board_mem
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        we,
    input  logic [7:0]  wr_addr,
    input  cell_state_t wr_data,
    input  logic [7:0]  rd_addr,
    output cell_state_t rd_data
);

    logic [1:0] mem [0:BOARD_WORDS-1];
    logic [1:0] rd_data_reg;

    // Write and registered read share the edge; the read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_reg <= mem[rd_addr];
    end

    assign rd_data = cell_state_t'(rd_data_reg);

endmodule

// File: rtl/draw_board.sv
// Board overlay in the VGA chain: paints ship/hit/miss cells of a 12x12 board
// of 32-pixel cells and, when DRAW_BOARD_CURSOR_EN is defined, a blinking
// cursor ring. Owns the board-state RAM and its clear sequencer. All timing
// fields are delayed by exactly two clocks.
module draw_board
    import game_pkg::*;
#(
    parameter int X_POS        = 0,
    parameter int Y_POS        = 0,
    parameter int BLINK_FRAMES = 30
)(
    input  logic       clk,
    input  logic       rst,
    vga_if.in          in,
    vga_if.out         out,
    input  logic       clear,
    input  logic       wr_en,
    input  logic [3:0] wr_col,
    input  logic [3:0] wr_row,
    input  logic [1:0] wr_state,
    input  logic [3:0] cur_col,
    input  logic [3:0] cur_row,
    output logic       busy
);

    // ---------------- clear sequencer ----------------
    clr_state_t  state_reg, state_next;
    logic [7:0]  clr_addr_reg, clr_addr_next;

    logic        mem_we;
    logic [7:0]  mem_wr_addr;
    cell_state_t mem_wr_data;

    // State register: reset starts a full clear from address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_CLEAR;
            clr_addr_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
        end
    end

    // Next state: a clear pulse always restarts; otherwise walk 0..143.
    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        if (clear) begin
            state_next    = ST_CLEAR;
            clr_addr_next = 8'd0;
        end else if (state_reg == ST_CLEAR) begin
            if (clr_addr_reg == 8'(BOARD_WORDS - 1)) begin
                state_next    = ST_IDLE;
                clr_addr_next = 8'd0;
            end else begin
                clr_addr_next = clr_addr_reg + 8'd1;
            end
        end
    end

    // Outputs: the sequencer owns the write port while clearing.
    always_comb begin
        busy        = (state_reg == ST_CLEAR);
        mem_we      = 1'b0;
        mem_wr_addr = cell_addr(wr_row, wr_col);
        mem_wr_data = cell_state_t'(wr_state);
        if (state_reg == ST_CLEAR) begin
            mem_we      = 1'b1;
            mem_wr_addr = clr_addr_reg;
            mem_wr_data = EMPTY;
        end else if (wr_en && (wr_col <= 4'd11) && (wr_row <= 4'd11)) begin
            mem_we = 1'b1;
        end
    end

    // ---------------- stage 1: hit test and memory read ----------------
    logic signed [11:0] lx, ly;
    logic               on_board;
    logic [3:0]         col, row;
    logic [4:0]         ox, oy;
    logic [7:0]         rd_addr;
    cell_state_t        rd_data;

    // Signed local coordinates so pixels left/above the origin never alias.
    assign lx       = $signed({1'b0, in.hcount}) - $signed(12'(X_POS));
    assign ly       = $signed({1'b0, in.vcount}) - $signed(12'(Y_POS));
    assign on_board = (lx >= 12'sd0) && (lx < 12'sd384) && (ly >= 12'sd0) && (ly < 12'sd384);
    assign col      = lx[8:5];
    assign row      = ly[8:5];
    assign ox       = lx[4:0];
    assign oy       = ly[4:0];
    assign rd_addr  = on_board ? cell_addr(row, col) : 8'd0;

    board_mem u_board_mem (
        .clk     (clk),
        .we      (mem_we),
        .wr_addr (mem_wr_addr),
        .wr_data (mem_wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    logic [10:0] s1_vcount_reg, s1_hcount_reg;
    logic        s1_vsync_reg, s1_hsync_reg, s1_vblnk_reg, s1_hblnk_reg;
    logic [11:0] s1_rgb_reg;
    logic        board_reg, fill_reg, masked_reg;

    // Stage-1 register: timing fields plus per-pixel board decisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vcount_reg <= '0;
            s1_hcount_reg <= '0;
            s1_vsync_reg  <= 1'b0;
            s1_hsync_reg  <= 1'b0;
            s1_vblnk_reg  <= 1'b0;
            s1_hblnk_reg  <= 1'b0;
            s1_rgb_reg    <= '0;
            board_reg     <= 1'b0;
            fill_reg      <= 1'b0;
            masked_reg    <= 1'b0;
        end else begin
            s1_vcount_reg <= in.vcount;
            s1_hcount_reg <= in.hcount;
            s1_vsync_reg  <= in.vsync;
            s1_hsync_reg  <= in.hsync;
            s1_vblnk_reg  <= in.vblnk;
            s1_hblnk_reg  <= in.hblnk;
            s1_rgb_reg    <= in.rgb;
            board_reg     <= on_board;
            fill_reg      <= (ox >= 5'd2) && (oy >= 5'd2);
            masked_reg    <= (state_reg == ST_CLEAR);
        end
    end

`ifdef DRAW_BOARD_CURSOR_EN
    // ---------------- cursor and blink ----------------
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] blink_cnt_reg;
    logic          phase_reg, vsync_prev_reg;
    logic          cursor_hit, cursor_reg;

    // Blink counter: one count per frame (vsync rising edge), phase flips on wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_reg  <= '0;
            phase_reg      <= 1'b1;
            vsync_prev_reg <= 1'b0;
        end else begin
            vsync_prev_reg <= in.vsync;
            if (in.vsync && !vsync_prev_reg) begin
                if (blink_cnt_reg == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt_reg <= '0;
                    phase_reg     <= ~phase_reg;
                end else begin
                    blink_cnt_reg <= blink_cnt_reg + 1'b1;
                end
            end
        end
    end

    // Cursor match: ring pixels of the selected cell while the phase is on.
    always_comb begin
        cursor_hit = 1'b0;
        if (phase_reg && on_board && (cur_col <= 4'd11) && (cur_row <= 4'd11)
            && (col == cur_col) && (row == cur_row)) begin
            cursor_hit = ring_offset(ox) || ring_offset(oy);
        end
    end

    // Cursor match travels with the stage-1 pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            cursor_reg <= 1'b0;
        end else begin
            cursor_reg <= cursor_hit;
        end
    end
`else
    logic unused_cursor;
    assign unused_cursor = ^{cur_col, cur_row};
`endif

    // ---------------- stage 2: colour select ----------------
    logic [11:0] pix_rgb;

    // Colour select: cell fill (masked while clearing), cursor on top, blanking last.
    always_comb begin
        pix_rgb = s1_rgb_reg;
        if (board_reg && fill_reg) begin
            if (!masked_reg) begin
                pix_rgb = cell_rgb(rd_data, s1_rgb_reg);
            end
`ifdef DRAW_BOARD_CURSOR_EN
            if (cursor_reg) begin
                pix_rgb = CURSOR_RGB;
            end
`endif
        end
        if (s1_hblnk_reg || s1_vblnk_reg) begin
            pix_rgb = 12'h000;
        end
    end

    // Output register: second pipeline stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            out.vcount <= '0;
            out.hcount <= '0;
            out.vsync  <= 1'b0;
            out.hsync  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.vcount <= s1_vcount_reg;
            out.hcount <= s1_hcount_reg;
            out.vsync  <= s1_vsync_reg;
            out.hsync  <= s1_hsync_reg;
            out.vblnk  <= s1_vblnk_reg;
            out.hblnk  <= s1_hblnk_reg;
            out.rgb    <= pix_rgb;
        end
    end

endmodule
